adc_sample_averager: RTL and testbench
======================================

Name: adc_sample_averager

Overview:
- Downstream consumer of the 3-bit flash-ADC thermometer decoder output (code + end-of-conversion flag).
- Detects each completed conversion on the eoc rising edge, captures the code, and accumulates 2^LOG2_AVG samples into one oversampled sum.
- Buffers sums in a small FIFO drained over a valid/ready handshake toward the bus-side logic.

Parameters:
- CODE_W, 3, width of the decoder code input.
- LOG2_AVG, 2, log2 of samples per sum; legal range 0..4.
- FIFO_DEPTH, 4, result FIFO entries; power of 2, at least 2.

Ports:
- wb_clk_i  input  1  clock; single clock domain.
- wb_rst_i  input  1  reset; asynchronous, active-high.
- code_i  input  CODE_W  decoder result bits.
- eoc_i  input  1  decoder end-of-conversion; low while sampling, high once the result is valid.
- enable_i  input  1  when low, conversions are ignored.
- clear_i  input  1  synchronous flush of the accumulator, FIFO and overflow flag.
- sum_o  output  CODE_W+LOG2_AVG  FIFO head, i.e. the sum of 2^LOG2_AVG codes.
- sum_valid_o  output  1  FIFO not empty.
- sum_ready_i  input  1  consumer accepts sum_o.
- level_o  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow_o  output  1  sticky; a completed sum was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - acc=0, cnt=0, FIFO empty.
  - sum_o=0, sum_valid_o=0, level_o=0, overflow_o=0.
  - eoc_q=1, so an eoc already high out of reset is not counted.
- Strobe:
  - strobe = eoc_i & ~eoc_q & enable_i; eoc_q registers eoc_i every cycle regardless of enable_i.
  - code_i is sampled in the strobe cycle; the decoder updates code and eoc on the same edge.
- Accumulate on strobe:
  - If cnt != 2^LOG2_AVG-1: acc += code_i, cnt++.
  - Else push acc+code_i into the FIFO, then acc=0, cnt=0.
  - acc width is CODE_W+LOG2_AVG; it cannot overflow because the max is 7*2^LOG2_AVG.
- LOG2_AVG=0: every strobe pushes code_i directly.
- Push latency: sum_valid_o rises on the clock edge after the completing strobe. There is no combinational path from inputs to sum_o/sum_valid_o.
- Handshake:
  - A pop occurs when sum_valid_o & sum_ready_i.
  - sum_o is show-ahead (head visible while valid) and stable while valid and not ready.
  - sum_o holds its last value when the FIFO is empty.
- Simultaneous events:
  - Push and pop with the FIFO full: push accepted, level unchanged.
  - Push and pop with the FIFO non-full and non-empty: level unchanged.
  - Push with the FIFO empty: pop is impossible that cycle.
- FIFO full, push, no pop: the sum is dropped, overflow_o is set, and acc/cnt still restart.
- Pointer wrap: pointers are LOG2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when all bits are equal.
- clear_i:
  - Highest priority after reset.
  - Zeroes acc, cnt, pointers and overflow_o; sum_valid_o=0 next cycle.
  - A strobe or pop in the same cycle is discarded.
  - eoc_q still updates.
- enable_i low mid-accumulation: acc and cnt hold; accumulation resumes when enable_i returns high.
- Async reset mid-accumulation: state returns to reset values immediately; a partial sum is lost.

Decomposition:
- Shared package adc_pkg holds:
  - ADC_CODE_W=3
  - ADC_COMP_N=7
  - a typedef adc_code_t.
- Sub-module adc_result_fifo: parameterised synchronous FIFO with push/pop/full/empty/level. It owns all pointer and wrap logic.
- The top level holds the edge detect, accumulator and overflow flag.

Test Plan:
- Reset with eoc_i=1 held, then 3 cycles idle -> no strobe, level_o=0, sum_valid_o=0.
- LOG2_AVG=2, enable=1, sum_ready_i=1; four conversions with codes 7,3,5,1 (eoc pulses low then high) -> one sum_o=16 (5'h10), valid the cycle after the 4th strobe, popped the same cycle.
- sum_ready_i=0; 5 groups of four code-7 conversions -> level_o=4, sum_o=28 stable, overflow_o=1 after the 5th group. Then ready=1 drains exactly 4 values of 28.
- Full FIFO with a push and pop in the same cycle -> level_o stays 4, overflow_o stays 0, and the new sum appears last in drain order.
- After 2 strobes (acc=6), enable_i=0 for 3 eoc pulses, then enable_i=1 and 2 more strobes of code 2 -> sum_o=10.
- After 2 strobes, assert clear_i concurrently with a strobe -> acc=0, cnt=0, no push. The next 4 strobes of code 1 -> sum_o=4.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the flash-ADC datapath: code width, comparator count
// and the code type used by everything downstream of the thermometer decoder.
package adc_pkg;

  localparam int ADC_CODE_W = 3;
  localparam int ADC_COMP_N = 7;

  typedef logic [ADC_CODE_W-1:0] adc_code_t;

endpackage : adc_pkg

// File: rtl/adc_result_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that full and
// empty are distinguishable. The head output holds its last value while empty.
module adc_result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  // A full FIFO still accepts a push when a pop frees the head in the same cycle.
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & (~full | do_pop) & ~clear;

  assign head = mem[rd_ptr[AW-1:0]];
  assign dout = empty ? last_q : head;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      if (!empty) last_q <= head;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= head;
      end
    end
  end

  // NOTE: the storage array has no reset; an entry is only observed after it
  // has been written, so resetting it would add cost without changing behaviour.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule : adc_result_fifo

// File: rtl/adc_sample_averager.sv
// Detects each completed flash-ADC conversion, sums 2^LOG2_AVG codes and queues
// the oversampled sums in a small FIFO drained over valid/ready.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int CODE_W     = ADC_CODE_W,
  parameter int LOG2_AVG   = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int SUM_W     = CODE_W + LOG2_AVG,
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              eoc_i,
  input  logic              enable_i,
  input  logic              clear_i,
  output logic [SUM_W-1:0]  sum_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i,
  output logic [LVL_W-1:0]  level_o,
  output logic              overflow_o
);

  // With LOG2_AVG=0 the counter degenerates to a constant 0 that always matches.
  localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  logic             eoc_q;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             strobe;
  logic             last;
  logic [SUM_W-1:0] acc_sum;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  // NOTE: every signal driven here gets a default first, so no path through the
  // block can leave it unassigned and infer a latch.
  always_comb begin
    strobe  = 1'b0;
    last    = 1'b0;
    acc_sum = '0;
    push    = 1'b0;
    pop     = 1'b0;
    strobe  = eoc_i & ~eoc_q & enable_i;
    last    = (cnt == CNT_LAST);
    acc_sum = acc + SUM_W'(code_i);
    push    = strobe & last & ~clear_i;
    pop     = ~fifo_empty & sum_ready_i & ~clear_i;
  end

  // eoc_q resets high so an eoc already asserted out of reset is not a new edge.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      eoc_q      <= 1'b1;
      acc        <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else begin
      eoc_q <= eoc_i;
      if (clear_i) begin
        acc        <= '0;
        cnt        <= '0;
        overflow_o <= 1'b0;
      end else if (strobe) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
          if (fifo_full && !pop) overflow_o <= 1'b1;
        end else begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  adc_result_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (clear_i),
    .push  (push),
    .din   (acc_sum),
    .pop   (pop),
    .dout  (sum_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_o)
  );

  assign sum_valid_o = ~fifo_empty;

endmodule : adc_sample_averager

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager (LOG2_AVG=2, FIFO_DEPTH=4): inputs are
// driven and outputs sampled on the falling clock edge.
module tb_adc_sample_averager;
  import adc_pkg::*;

  logic      wb_clk_i = 1'b0;
  logic      wb_rst_i;
  adc_code_t code_i;
  logic      eoc_i;
  logic      enable_i;
  logic      clear_i;
  logic [4:0] sum_o;
  logic      sum_valid_o;
  logic      sum_ready_i;
  logic [2:0] level_o;
  logic      overflow_o;

  int n_cmp = 0;
  int n_bad = 0;

  adc_sample_averager #(.CODE_W(ADC_CODE_W), .LOG2_AVG(2), .FIFO_DEPTH(4)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .code_i      (code_i),
    .eoc_i       (eoc_i),
    .enable_i    (enable_i),
    .clear_i     (clear_i),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .level_o     (level_o),
    .overflow_o  (overflow_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One conversion: eoc low for a cycle, then high together with the new code.
  // Returns at the falling edge just before the strobe's rising edge.
  task automatic conv(input adc_code_t c, input logic en);
    @(negedge wb_clk_i);
    eoc_i    = 1'b0;
    enable_i = en;
    @(negedge wb_clk_i);
    eoc_i  = 1'b1;
    code_i = c;
  endtask

  task automatic group(input adc_code_t c);
    for (int k = 0; k < 4; k++) conv(c, 1'b1);
  endtask

  initial begin
    wb_rst_i    = 1'b1;
    code_i      = '0;
    eoc_i       = 1'b1;
    enable_i    = 1'b1;
    clear_i     = 1'b0;
    sum_ready_i = 1'b1;

    // Reset with eoc held high, then idle: no strobe may occur.
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_level", level_o, 0);
    check("rst_valid", sum_valid_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_ovf", overflow_o, 0);

    // 7+3+5+1 = 16, valid one edge after the 4th strobe, popped immediately.
    conv(7, 1'b1); conv(3, 1'b1); conv(5, 1'b1); conv(1, 1'b1);
    @(negedge wb_clk_i);
    check("basic_valid", sum_valid_o, 1);
    check("basic_sum", sum_o, 16);
    check("basic_level", level_o, 1);
    @(negedge wb_clk_i);
    check("basic_popped", sum_valid_o, 0);
    check("basic_hold", sum_o, 16);

    // Fill with 28s, fifth group overflows.
    sum_ready_i = 1'b0;
    for (int g = 0; g < 4; g++) group(ADC_COMP_N);
    @(negedge wb_clk_i);
    check("fill_level", level_o, 4);
    check("fill_ovf", overflow_o, 0);
    group(ADC_COMP_N);
    @(negedge wb_clk_i);
    check("ovf_set", overflow_o, 1);
    check("ovf_level", level_o, 4);
    check("ovf_sum", sum_o, 28);
    sum_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain28_valid", sum_valid_o, 1);
      check("drain28_sum", sum_o, 28);
      @(negedge wb_clk_i);
    end
    check("drain28_empty", sum_valid_o, 0);
    check("drain28_ovf_sticky", overflow_o, 1);

    // Clear drops the sticky flag.
    clear_i = 1'b1;
    @(negedge wb_clk_i);
    clear_i = 1'b0;
    check("clr_ovf", overflow_o, 0);

    // Full FIFO (4,8,12,16) plus a push and pop in the same cycle.
    sum_ready_i = 1'b0;
    for (int g = 1; g <= 4; g++) group(adc_code_t'(g));
    conv(5, 1'b1); conv(5, 1'b1); conv(5, 1'b1); conv(5, 1'b1);
    sum_ready_i = 1'b1;
    @(negedge wb_clk_i);
    sum_ready_i = 1'b0;
    check("pp_level", level_o, 4);
    check("pp_ovf", overflow_o, 0);
    check("pp_head", sum_o, 8);
    sum_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_drain", sum_o, 8 + 4 * i);
      @(negedge wb_clk_i);
    end
    check("pp_empty", sum_valid_o, 0);

    // Disabled conversions are ignored: 3+3 + 2+2 = 10.
    conv(3, 1'b1); conv(3, 1'b1);
    conv(7, 1'b0); conv(7, 1'b0); conv(7, 1'b0);
    conv(2, 1'b1);
    @(negedge wb_clk_i);
    check("en_no_push", sum_valid_o, 0);
    conv(2, 1'b1);
    @(negedge wb_clk_i);
    check("en_valid", sum_valid_o, 1);
    check("en_sum", sum_o, 10);
    @(negedge wb_clk_i);
    check("en_popped", level_o, 0);

    // Clear together with a strobe discards both the partial sum and the strobe.
    conv(1, 1'b1); conv(1, 1'b1);
    conv(1, 1'b1);
    clear_i = 1'b1;
    @(negedge wb_clk_i);
    clear_i = 1'b0;
    check("clr_level", level_o, 0);
    conv(1, 1'b1); conv(1, 1'b1); conv(1, 1'b1);
    @(negedge wb_clk_i);
    check("clr_no_early", sum_valid_o, 0);
    conv(1, 1'b1);
    @(negedge wb_clk_i);
    check("clr_valid", sum_valid_o, 1);
    check("clr_sum", sum_o, 4);

    // Async reset mid-accumulation with a queued entry.
    @(negedge wb_clk_i);
    sum_ready_i = 1'b0;
    group(ADC_COMP_N);
    @(negedge wb_clk_i);
    check("ar_pre_level", level_o, 1);
    conv(5, 1'b1); conv(5, 1'b1);
    @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check("ar_level", level_o, 0);
    check("ar_valid", sum_valid_o, 0);
    check("ar_sum", sum_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i    = 1'b0;
    sum_ready_i = 1'b1;
    group(1);
    @(negedge wb_clk_i);
    check("ar_after_valid", sum_valid_o, 1);
    check("ar_after_sum", sum_o, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_adc_sample_averager
